// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO: Gray/binary conversion and
// the pointer-width / depth pattern used by every pointer-side block.
package fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend into this width.
  localparam int unsigned MAX_PW = 32;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic int unsigned ptr_width(input int unsigned addr_size);
    return addr_size + 1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // Zero upper bits decode to zero upper bits, so the result is valid for
  // any pointer width up to MAX_PW once truncated back to that width.
  function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] gray);
    logic [MAX_PW-1:0] bin;
    bin[MAX_PW-1] = gray[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain for clock-domain crossings; no logic between stages so
// every stage after the first only ever sees a settled value.
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES < 1) begin : g_bad_stages
    $error("sync_chain: STAGES must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_ptr_gray.sv
// Destination-side pointer synchroniser: Gray chain, binary decode, advance
// since the previous edge, and a flag for jumps no FIFO pointer can make.
module sync_ptr_gray
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ERR_STICKY  = 1'b1,
  localparam int unsigned PW = ptr_width(ADDR_SIZE),
  localparam int unsigned D  = fifo_depth(ADDR_SIZE)
) (
  input  logic          w_Clk,
  input  logic          w_Rst,
  input  logic [PW-1:0] r_GrayPtr,
  input  logic          err_Clr,
  output logic [PW-1:0] wsync_GrayPtr,
  output logic [PW-1:0] wsync_BinPtr,
  output logic          ptr_Adv,
  output logic [PW-1:0] ptr_Delta,
  output logic          gray_Err
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_ptr_gray: SYNC_STAGES must be within 2..4");
  end

  localparam logic [PW-1:0] DEPTH_PW = PW'(D);

  logic [PW-1:0] gray_sync;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] bin_q,   bin_d;
  logic [PW-1:0] delta_q, delta_d;
  logic          adv_q,   adv_d;
  logic          err_q,   err_d;
  logic          jump_bad;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk_i   (w_Clk),
    .rst_n_i (w_Rst),
    .d_i     (r_GrayPtr),
    .q_o     (gray_sync)
  );

  assign bin_next = PW'(gray2bin(MAX_PW'(gray_sync)));

  always_comb begin
    delta_d  = bin_next - bin_q;
    bin_d    = bin_next;
    adv_d    = (delta_d != '0);
    // A full FIFO is exactly D ahead, so only strictly larger jumps are bad.
    jump_bad = (delta_d > DEPTH_PW);
    err_d    = err_q;
    if (ERR_STICKY) begin
      if (jump_bad) begin
        err_d = 1'b1;
      end else if (err_Clr) begin
        err_d = 1'b0;
      end
    end else begin
      err_d = jump_bad;
    end
  end

  always_ff @(posedge w_Clk) begin
    if (!w_Rst) begin
      bin_q   <= '0;
      delta_q <= '0;
      adv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      delta_q <= delta_d;
      adv_q   <= adv_d;
      err_q   <= err_d;
    end
  end

  assign wsync_GrayPtr = gray_sync;
  assign wsync_BinPtr  = bin_q;
  assign ptr_Delta     = delta_q;
  assign ptr_Adv       = adv_q;
  assign gray_Err      = err_q;

endmodule
